hack_cpu_core: RTL and testbench

HACK_CPU_CORE -- requirements
Module: hack_cpu_core

---
 rtl/hack_cpu_core.sv | 89 ++++++++
 tb/tb_hack_cpu_core.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/hack_cpu_core.sv
// Hack CPU datapath and control: A, D and PC registers around an external ALU.
// C-instruction fields drive the ALU; results load A/D and resolve jumps.
module hack_cpu_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instruction,
  input  logic        instr_valid,
  input  logic [15:0] inM,
  input  logic [15:0] alu_out,
  input  logic        alu_zr,
  input  logic        alu_ng,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic        alu_zx,
  output logic        alu_nx,
  output logic        alu_zy,
  output logic        alu_ny,
  output logic        alu_f,
  output logic        alu_no,
  output logic [15:0] outM,
  output logic        writeM,
  output logic [14:0] addressM,
  output logic [14:0] pc
);

  logic [15:0] a_q, a_d;
  logic [15:0] d_q, d_d;
  logic [14:0] pc_q, pc_d;

  logic        isC;
  logic        selM;
  logic        destA, destD, destM;
  logic        jlt, jeq, jgt;
  logic        jump;
  logic [14:0] pcInc;

  assign isC   = instruction[15];
  assign selM  = instruction[12];
  assign destA = instruction[5];
  assign destD = instruction[4];
  assign destM = instruction[3];
  assign jlt   = instruction[2];
  assign jeq   = instruction[1];
  assign jgt   = instruction[0];

  assign alu_x = d_q;
  assign alu_y = selM ? inM : a_q;

  // ALU control is only meaningful for C-instructions; A-instructions carry data in these bits.
  assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = isC ? instruction[11:6] : 6'b0;

  assign outM     = alu_out;
  assign writeM   = instr_valid & rst_n & isC & destM;
  assign addressM = a_q[14:0];
  assign pc       = pc_q;

  assign jump  = isC & ((jlt & alu_ng) | (jeq & alu_zr) | (jgt & ~alu_ng & ~alu_zr));
  assign pcInc = pc_q + 15'd1;

  // Jump target uses the pre-update A, so a dA write and a jump in one instruction never interact.
  always_comb begin
    a_d  = a_q;
    d_d  = d_q;
    pc_d = pc_q;
    if (instr_valid) begin
      if (!isC) begin
        a_d  = instruction;
        pc_d = pcInc;
      end else begin
        if (destA) a_d = alu_out;
        if (destD) d_d = alu_out;
        pc_d = jump ? a_q[14:0] : pcInc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q  <= 16'h0000;
      d_q  <= 16'h0000;
      pc_q <= 15'h0000;
    end else begin
      a_q  <= a_d;
      d_q  <= d_d;
      pc_q <= pc_d;
    end
  end

endmodule

// File: tb/tb_hack_cpu_core.sv
// Directed bench for hack_cpu_core; a behavioural Hack ALU model closes the loop
// on the external ALU ports and expected values are hand-computed per step.
module tb_hack_cpu_core;

  logic        clk;
  logic        rst_n;
  logic [15:0] instruction;
  logic        instr_valid;
  logic [15:0] inM;
  logic [15:0] alu_out;
  logic        alu_zr;
  logic        alu_ng;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
  logic [15:0] outM;
  logic        writeM;
  logic [14:0] addressM;
  logic [14:0] pc;

  int errors = 0;
  int checks = 0;

  hack_cpu_core dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .inM         (inM),
    .alu_out     (alu_out),
    .alu_zr      (alu_zr),
    .alu_ng      (alu_ng),
    .alu_x       (alu_x),
    .alu_y       (alu_y),
    .alu_zx      (alu_zx),
    .alu_nx      (alu_nx),
    .alu_zy      (alu_zy),
    .alu_ny      (alu_ny),
    .alu_f       (alu_f),
    .alu_no      (alu_no),
    .outM        (outM),
    .writeM      (writeM),
    .addressM    (addressM),
    .pc          (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference Hack ALU standing in for the external one.
  logic [15:0] x1, x2, y1, y2, r1;
  always_comb begin
    x1      = alu_zx ? 16'h0000 : alu_x;
    x2      = alu_nx ? ~x1 : x1;
    y1      = alu_zy ? 16'h0000 : alu_y;
    y2      = alu_ny ? ~y1 : y1;
    r1      = alu_f ? (x2 + y2) : (x2 & y2);
    alu_out = alu_no ? ~r1 : r1;
    alu_zr  = (alu_out == 16'h0000);
    alu_ng  = alu_out[15];
  end

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%04h expected=0x%04h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] instr, input logic valid);
    instruction = instr;
    instr_valid = valid;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    inM   = 16'h0000;
    applyStimulus(16'hE308, 1'b1);
    checkOutput("writeM_in_reset", {15'd0, writeM}, 16'h0000);
    tick();
    checkOutput("rst_pc", {1'b0, pc}, 16'h0000);
    checkOutput("rst_addressM", {1'b0, addressM}, 16'h0000);
    checkOutput("rst_aluX", alu_x, 16'h0000);
    checkOutput("rst_writeM", {15'd0, writeM}, 16'h0000);

    rst_n = 1'b1;
    applyStimulus(16'h0005, 1'b1);
    checkOutput("aInstr_ctrl_zero", {10'd0, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, 16'h0000);
    tick();
    checkOutput("aInstr_addressM", {1'b0, addressM}, 16'h0005);
    checkOutput("aInstr_pc", {1'b0, pc}, 16'h0001);
    applyStimulus(16'hEC10, 1'b1);
    tick();
    checkOutput("dEqA_D", alu_x, 16'h0005);
    checkOutput("dEqA_pc", {1'b0, pc}, 16'h0002);
    checkOutput("dEqA_addressM", {1'b0, addressM}, 16'h0005);

    applyStimulus(16'hE308, 1'b1);
    checkOutput("mEqD_writeM", {15'd0, writeM}, 16'h0001);
    checkOutput("mEqD_outM", outM, 16'h0005);
    checkOutput("mEqD_addressM", {1'b0, addressM}, 16'h0005);
    tick();
    checkOutput("mEqD_pc", {1'b0, pc}, 16'h0003);

    applyStimulus(16'hE308, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall_writeM", {15'd0, writeM}, 16'h0000);
      tick();
    end
    checkOutput("stall_pc", {1'b0, pc}, 16'h0003);
    checkOutput("stall_A", {1'b0, addressM}, 16'h0005);
    checkOutput("stall_D", alu_x, 16'h0005);

    applyStimulus(16'h0008, 1'b1);
    checkOutput("aInstr_bit3_writeM", {15'd0, writeM}, 16'h0000);
    tick();
    checkOutput("a8_pc", {1'b0, pc}, 16'h0004);

    applyStimulus(16'hEA90, 1'b1);
    tick();
    checkOutput("dZero_D", alu_x, 16'h0000);
    applyStimulus(16'h0100, 1'b1);
    tick();
    applyStimulus(16'hE302, 1'b1);
    tick();
    checkOutput("jeq_taken_pc", {1'b0, pc}, 16'h0100);

    applyStimulus(16'h0007, 1'b1);
    tick();
    applyStimulus(16'hEC10, 1'b1);
    tick();
    checkOutput("d7_D", alu_x, 16'h0007);
    applyStimulus(16'h0100, 1'b1);
    tick();
    applyStimulus(16'hE302, 1'b1);
    tick();
    checkOutput("jeq_not_taken_pc", {1'b0, pc}, 16'h0104);

    applyStimulus(16'h0100, 1'b1);
    tick();
    applyStimulus(16'hEFE7, 1'b1);
    tick();
    checkOutput("dA_jump_old_target", {1'b0, pc}, 16'h0100);
    checkOutput("dA_jump_newA", {1'b0, addressM}, 16'h0001);

    inM = 16'h1234;
    applyStimulus(16'hFC10, 1'b1);
    checkOutput("aBit_aluY_inM", alu_y, 16'h1234);
    tick();
    checkOutput("dEqM_D", alu_x, 16'h1234);

    applyStimulus(16'h7FFF, 1'b1);
    tick();
    applyStimulus(16'hEA87, 1'b1);
    tick();
    checkOutput("jmp_pc_7fff", {1'b0, pc}, 16'h7FFF);
    applyStimulus(16'h0000, 1'b1);
    tick();
    checkOutput("wrap_pc", {1'b0, pc}, 16'h0000);

    applyStimulus(16'h0042, 1'b1);
    tick();
    rst_n = 1'b0;
    applyStimulus(16'hEC10, 1'b1);
    checkOutput("midReset_writeM", {15'd0, writeM}, 16'h0000);
    tick();
    checkOutput("midReset_pc", {1'b0, pc}, 16'h0000);
    checkOutput("midReset_A", {1'b0, addressM}, 16'h0000);
    checkOutput("midReset_D", alu_x, 16'h0000);
    rst_n = 1'b1;
    applyStimulus(16'h0003, 1'b1);
    tick();
    checkOutput("resume_pc", {1'b0, pc}, 16'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
